muldiv_arbiter: RTL

- Sequences and shares the single iterative multiply/divide unit between two requesters, e.g. the integer pipeline (port 0) and a second issue source such as a debug or coprocessor path (port 1).
- Performs round-robin arbitration and issues exactly one operation to the unit at a time.
- Waits for the unit's completion pulse, then holds the result for the owning requester until it is accepted or killed.

---
 rtl/muldiv_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/muldiv_arbiter.sv
// Purpose: round-robin sharing of one iterative mul/div unit between two requesters, one operation in flight.
// Latency: grant at T, md_enable at T+1, resp_valid the cycle after md_ready (reuse hit: resp_valid at T+1).
// Backpressure: response held in RESP until resp_ready or kill of the owner; no new grant until back in IDLE.
//
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready[1:0], req{0,1}_op/_rdata1/_rdata2 : request side, req_ready pulses in the grant cycle
//   kill[1:0]                   : owner flush, suppresses that requester's pending response
//   resp_valid/resp_ready[1:0], resp_result : response side, one shared result bus
//   md_enable/md_op/md_rdata1/md_rdata2, md_result/md_ready : iterative unit interface
//   busy                        : arbiter not idle
// Optional: define MULDIV_ARB_REUSE_EN to add a one-entry last-result cache that bypasses the unit on a hit.

module muldiv_arbiter #(
   parameter int XLEN = 32,
   parameter int OPW  = 8
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [OPW-1:0]  req0_op,
   input  logic [XLEN-1:0] req0_rdata1,
   input  logic [XLEN-1:0] req0_rdata2,
   input  logic [OPW-1:0]  req1_op,
   input  logic [XLEN-1:0] req1_rdata1,
   input  logic [XLEN-1:0] req1_rdata2,
   input  logic [1:0]      kill,
   output logic [1:0]      resp_valid,
   input  logic [1:0]      resp_ready,
   output logic [XLEN-1:0] resp_result,
   output logic            md_enable,
   output logic [OPW-1:0]  md_op,
   output logic [XLEN-1:0] md_rdata1,
   output logic [XLEN-1:0] md_rdata2,
   input  logic [XLEN-1:0] md_result,
   input  logic            md_ready,
   output logic            busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      BUSY  = 2'd2,
      RESP  = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic            rr_ptr_q, rr_ptr_d;
   logic            owner_q, owner_d;
   logic            killed_q, killed_d;
   logic [OPW-1:0]  op_q;
   logic [XLEN-1:0] rdata1_q, rdata2_q, result_q;

   logic            grant_vld;
   logic            grant_idx;
   logic [OPW-1:0]  grant_op;
   logic [XLEN-1:0] grant_rdata1, grant_rdata2;
   logic            owner_kill;
   logic            lat_en;
   logic            res_en;
   logic [XLEN-1:0] res_d;
   logic            hit;
   logic [XLEN-1:0] hit_result;

   // rr_ptr only breaks ties; a lone requester always wins.
   assign grant_vld    = (state_q == IDLE) && (req_valid != 2'b00);
   assign grant_idx    = (req_valid == 2'b11) ? rr_ptr_q : req_valid[1];
   assign grant_op     = grant_idx ? req1_op     : req0_op;
   assign grant_rdata1 = grant_idx ? req1_rdata1 : req0_rdata1;
   assign grant_rdata2 = grant_idx ? req1_rdata2 : req0_rdata2;
   assign owner_kill   = kill[owner_q];

`ifdef MULDIV_ARB_REUSE_EN
   logic            cache_vld_q;
   logic [OPW-1:0]  cache_op_q;
   logic [XLEN-1:0] cache_rdata1_q, cache_rdata2_q, cache_result_q;

   assign hit = cache_vld_q && (cache_op_q == grant_op) &&
                (cache_rdata1_q == grant_rdata1) && (cache_rdata2_q == grant_rdata2);
   assign hit_result = cache_result_q;

   // Killed completions are still architecturally valid results, so they refill the cache too.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cache_vld_q    <= 1'b0;
         cache_op_q     <= '0;
         cache_rdata1_q <= '0;
         cache_rdata2_q <= '0;
         cache_result_q <= '0;
      end else if ((state_q == BUSY) && md_ready) begin
         cache_vld_q    <= 1'b1;
         cache_op_q     <= op_q;
         cache_rdata1_q <= rdata1_q;
         cache_rdata2_q <= rdata2_q;
         cache_result_q <= md_result;
      end
   end
`else
   assign hit        = 1'b0;
   assign hit_result = '0;
`endif

   always_comb begin
      state_d    = state_q;
      rr_ptr_d   = rr_ptr_q;
      owner_d    = owner_q;
      killed_d   = killed_q;
      req_ready  = 2'b00;
      resp_valid = 2'b00;
      lat_en     = 1'b0;
      res_en     = 1'b0;
      res_d      = md_result;
      case (state_q)
         IDLE: begin
            if (grant_vld) begin
               req_ready[grant_idx] = 1'b1;
               lat_en  = 1'b1;
               owner_d = grant_idx;
               if (hit) begin
                  state_d = RESP;
                  res_en  = 1'b1;
                  res_d   = hit_result;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         ISSUE: begin
            killed_d = killed_q | owner_kill;
            state_d  = BUSY;
         end
         BUSY: begin
            // The unit cannot be aborted: a kill only marks the result for discard.
            killed_d = killed_q | owner_kill;
            if (md_ready) begin
               if (killed_q || owner_kill) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
               end else begin
                  state_d = RESP;
                  res_en  = 1'b1;
               end
            end
         end
         RESP: begin
            if (owner_kill) begin
               state_d  = IDLE;
               rr_ptr_d = ~owner_q;
            end else begin
               resp_valid[owner_q] = 1'b1;
               if (resp_ready[owner_q]) begin
                  state_d  = IDLE;
                  rr_ptr_d = ~owner_q;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (state_d == IDLE) killed_d = 1'b0;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         rr_ptr_q <= 1'b0;
         owner_q  <= 1'b0;
         killed_q <= 1'b0;
         op_q     <= '0;
         rdata1_q <= '0;
         rdata2_q <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         killed_q <= killed_d;
         if (lat_en) begin
            op_q     <= grant_op;
            rdata1_q <= grant_rdata1;
            rdata2_q <= grant_rdata2;
         end
         if (res_en) result_q <= res_d;
      end
   end

   assign md_enable   = (state_q == ISSUE);
   assign md_op       = op_q;
   assign md_rdata1   = rdata1_q;
   assign md_rdata2   = rdata2_q;
   assign resp_result = result_q;
   assign busy        = (state_q != IDLE);

endmodule
